// File: rtl/memory_stage.sv
// MEM stage of the 19-bit core: drives the data-memory handshake for word/byte
// loads and stores (byte stores as read-modify-write) and registers the M/W bundle.
module memory_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RDM,
    input  logic [18:0] WriteDataM,
    input  logic [18:0] ALUResultM,
    input  logic        Cant_ByteM,
    input  logic [18:0] mem_rdata,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [18:0] mem_wdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RDW,
    output logic [18:0] ALUResultW,
    output logic [18:0] ReadDataW,
    output logic        dbg_state_o
);

    // Handshake: a request is held (mem_req=1, address/data stable) until the
    // cycle mem_ready=1, which completes it; mem_ready is ignored when mem_req=0.
    typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [18:0] merged_q, merged_d;
    logic        capture;
    logic [18:0] load_data;
    logic        req_c, we_c, stall_c;

    logic mem_op, is_load, byte_store;
    assign mem_op     = MemWriteM | ResultSrcM;
    assign is_load    = ResultSrcM & ~MemWriteM;
    assign byte_store = MemWriteM & Cant_ByteM;

    assign mem_addr    = ALUResultM[14:0];
    assign dbg_state_o = state_q;

    always_comb begin
        state_d   = state_q;
        merged_d  = merged_q;
        req_c     = 1'b0;
        we_c      = 1'b0;
        stall_c   = 1'b0;
        capture   = 1'b0;
        mem_wdata = WriteDataM;
        load_data = 19'd0;
        unique case (state_q)
            IDLE: begin
                if (!mem_op) begin
                    capture = 1'b1;
                end else if (byte_store) begin
                    // Phase 1 always stalls: the write still has to follow.
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    if (mem_ready) begin
                        merged_d = {mem_rdata[18:8], WriteDataM[7:0]};
                        state_d  = RMW_WR;
                    end
                end else begin
                    req_c   = 1'b1;
                    we_c    = MemWriteM;
                    stall_c = ~mem_ready;
                    capture = mem_ready;
                    if (is_load)
                        load_data = Cant_ByteM ? {11'd0, mem_rdata[7:0]} : mem_rdata;
                end
            end
            RMW_WR: begin
                req_c     = 1'b1;
                we_c      = 1'b1;
                mem_wdata = merged_q;
                stall_c   = ~mem_ready;
                capture   = mem_ready;
                if (mem_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_req = req_c & ~reset;
    assign mem_we  = we_c & ~reset;
    assign StallM  = stall_c & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            merged_q <= 19'd0;
        end else begin
            state_q  <= state_d;
            merged_q <= merged_d;
        end
    end

    // Anything other than a completed bundle enters W as a bubble.
    always_ff @(posedge clk) begin
        if (reset || !capture) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            RDW        <= 5'd0;
            ALUResultW <= 19'd0;
            ReadDataW  <= 19'd0;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RDW        <= RDM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= load_data;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: single-cycle vector table plus hand-written
// multi-cycle sequences for waits, byte read-modify-write and reset mid-access.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM, mem_ready;
    logic [4:0]  RDM;
    logic [18:0] WriteDataM, ALUResultM, mem_rdata;
    logic        mem_req, mem_we, StallM, RegWriteW, ResultSrcW, dbg_state;
    logic [14:0] mem_addr;
    logic [18:0] mem_wdata, ALUResultW, ReadDataW;
    logic [4:0]  RDW;

    int n_checks = 0;
    int n_errors = 0;
    logic [18:0] exp_q[$];
    logic [18:0] mem_word;
    int          n_writes;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RDM(RDM), .WriteDataM(WriteDataM), .ALUResultM(ALUResultM),
        .Cant_ByteM(Cant_ByteM), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RDW(RDW),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .dbg_state_o(dbg_state)
    );

    // Single-word memory model: records every completed write.
    always @(posedge clk) begin
        if (mem_req && mem_we && mem_ready) begin
            mem_word <= mem_wdata;
            n_writes <= n_writes + 1;
        end
    end

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                         input logic [18:0] wd, input logic [18:0] alu, input logic cb,
                         input logic [18:0] rdata, input logic rdy);
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RDM = rd;
        WriteDataM = wd; ALUResultM = alu; Cant_ByteM = cb;
        mem_rdata = rdata; mem_ready = rdy;
    endtask

    task automatic check_w(input string tag, input logic rw, input logic rs, input logic [4:0] rd,
                           input logic [18:0] alu, input logic [18:0] rdw);
        check({tag, "_RegWriteW"}, 19'(RegWriteW), 19'(rw));
        check({tag, "_ResultSrcW"}, 19'(ResultSrcW), 19'(rs));
        check({tag, "_RDW"}, 19'(RDW), 19'(rd));
        check({tag, "_ALUResultW"}, ALUResultW, alu);
        check({tag, "_ReadDataW"}, ReadDataW, rdw);
    endtask

    typedef struct {
        logic        rw, mw, rs;
        logic [4:0]  rd;
        logic [18:0] wd, alu;
        logic        cb;
        logic [18:0] rdata;
        logic        rdy;
        logic        e_req, e_we;
        logic [14:0] e_addr;
        logic [18:0] e_wdata;
        logic        e_stall, e_rw, e_rs;
        logic [4:0]  e_rd;
        logic [18:0] e_alu, e_rdw;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // rw mw rs rd wd alu cb rdata rdy | req we addr wdata stall | W: rw rs rd alu rdata
        vecs[0] = '{1,0,0,5'd5, 19'h0,     19'h01234,0,19'h0,    0, 0,0,15'h1234,19'h0,    0, 1,0,5'd5, 19'h01234,19'h0};
        vecs[1] = '{1,0,1,5'd3, 19'h0,     19'h00040,0,19'h7ABCD,1, 1,0,15'h0040,19'h0,    0, 1,1,5'd3, 19'h00040,19'h7ABCD};
        vecs[2] = '{1,0,1,5'd4, 19'h0,     19'h00041,1,19'h7ABCD,1, 1,0,15'h0041,19'h0,    0, 1,1,5'd4, 19'h00041,19'h000CD};
        vecs[3] = '{0,1,0,5'd7, 19'h55555, 19'h00020,0,19'h0,    1, 1,1,15'h0020,19'h55555,0, 0,0,5'd7, 19'h00020,19'h0};
        vecs[4] = '{1,0,1,5'd9, 19'h0,     19'h00050,0,19'h11111,0, 1,0,15'h0050,19'h0,    1, 0,0,5'd0, 19'h0,    19'h0};
        vecs[5] = '{0,1,0,5'd6, 19'h2AAAA, 19'h00060,0,19'h0,    0, 1,1,15'h0060,19'h2AAAA,1, 0,0,5'd0, 19'h0,    19'h0};
        vecs[6] = '{1,1,1,5'd2, 19'h0F0F0, 19'h00070,0,19'h7FFFF,1, 1,1,15'h0070,19'h0F0F0,0, 1,1,5'd2, 19'h00070,19'h0};
        vecs[7] = '{1,0,0,5'd31,19'h0,     19'h7FFFF,0,19'h3C3C3,1, 0,0,15'h7FFF,19'h0,    0, 1,0,5'd31,19'h7FFFF,19'h0};
        vecs[8] = '{1,0,1,5'd8, 19'h0,     19'h00044,1,19'h000AB,0, 1,0,15'h0044,19'h0,    1, 0,0,5'd0, 19'h0,    19'h0};

        // Clock/reset: W outputs are loaded with garbage-free zeros by reset.
        mem_word = 19'h12345;
        n_writes = 0;
        reset = 1'b1;
        drive(1, 1, 1, 5'd17, 19'h7FFFF, 19'h7FFFF, 1, 19'h7FFFF, 1);
        @(negedge clk);
        check("rst_mem_req", 19'(mem_req), 19'd0);
        check("rst_mem_we", 19'(mem_we), 19'd0);
        check("rst_StallM", 19'(StallM), 19'd0);
        @(posedge clk); #1;
        check_w("rst", 0, 0, 5'd0, 19'h0, 19'h0);
        check("rst_state", 19'(dbg_state), 19'd0);
        @(negedge clk);
        reset = 1'b0;

        // Vector table, each applied in IDLE.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].rd, vecs[i].wd,
                  vecs[i].alu, vecs[i].cb, vecs[i].rdata, vecs[i].rdy);
            #1;
            check($sformatf("v%0d_mem_req", i), 19'(mem_req), 19'(vecs[i].e_req));
            check($sformatf("v%0d_mem_we", i), 19'(mem_we), 19'(vecs[i].e_we));
            check($sformatf("v%0d_mem_addr", i), 19'(mem_addr), 19'(vecs[i].e_addr));
            check($sformatf("v%0d_StallM", i), 19'(StallM), 19'(vecs[i].e_stall));
            if (vecs[i].e_we)
                check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            exp_q.push_back(vecs[i].e_rdw);
            @(posedge clk); #1;
            check_w($sformatf("v%0d", i), vecs[i].e_rw, vecs[i].e_rs, vecs[i].e_rd,
                    vecs[i].e_alu, exp_q.pop_front());
            @(negedge clk);
        end

        // Word load at 0x0040 with two wait cycles.
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 1, 5'd12, 19'h0, 19'h00040, 0, (c == 2) ? 19'h7ABCD : 19'h0, c == 2);
            #1;
            check($sformatf("wl_c%0d_StallM", c), 19'(StallM), (c == 2) ? 19'd0 : 19'd1);
            check($sformatf("wl_c%0d_mem_req", c), 19'(mem_req), 19'd1);
            @(posedge clk); #1;
            if (c < 2) check_w($sformatf("wl_c%0d", c), 0, 0, 5'd0, 19'h0, 19'h0);
            else       check_w("wl_done", 1, 1, 5'd12, 19'h00040, 19'h7ABCD);
            @(negedge clk);
        end

        // Byte store 0xEE into word 0x12345 at 0x0010, zero-wait.
        mem_word = 19'h12345;
        n_writes = 0;
        drive(0, 1, 0, 5'd0, 19'h000EE, 19'h00010, 1, mem_word, 1);
        #1;
        check("bs1_mem_req", 19'(mem_req), 19'd1);
        check("bs1_mem_we", 19'(mem_we), 19'd0);
        check("bs1_StallM", 19'(StallM), 19'd1);
        @(posedge clk); #1;
        check("bs1_state", 19'(dbg_state), 19'd1);
        check("bs1_RegWriteW_bubble", 19'(RegWriteW), 19'd0);
        check("bs1_ALUResultW_bubble", ALUResultW, 19'h0);
        @(negedge clk);
        mem_rdata = 19'h0;
        #1;
        check("bs2_mem_we", 19'(mem_we), 19'd1);
        check("bs2_mem_wdata", mem_wdata, 19'h123EE);
        check("bs2_mem_addr", 19'(mem_addr), 19'h00010);
        check("bs2_StallM", 19'(StallM), 19'd0);
        @(posedge clk); #1;
        check("bs2_state", 19'(dbg_state), 19'd0);
        check("bs2_ALUResultW", ALUResultW, 19'h00010);
        check("bs_mem_word", mem_word, 19'h123EE);
        check("bs_writes", 19'(n_writes), 19'd1);
        @(negedge clk);

        // Byte store with one wait cycle in the write phase.
        drive(0, 1, 0, 5'd0, 19'h00011, 19'h00010, 1, mem_word, 1);
        @(posedge clk); #1;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("bsw_wait_StallM", 19'(StallM), 19'd1);
        check("bsw_wait_mem_wdata", mem_wdata, 19'h12311);
        @(posedge clk); #1;
        check("bsw_wait_state", 19'(dbg_state), 19'd1);
        check("bsw_wait_mem_word", mem_word, 19'h123EE);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        check("bsw_done_StallM", 19'(StallM), 19'd0);
        @(posedge clk); #1;
        check("bsw_mem_word", mem_word, 19'h12311);
        check("bsw_state", 19'(dbg_state), 19'd0);
        @(negedge clk);

        // Byte store aborted by reset during the write phase.
        n_writes = 0;
        drive(0, 1, 0, 5'd0, 19'h000AA, 19'h00010, 1, mem_word, 1);
        @(posedge clk); #1;
        check("rr_state", 19'(dbg_state), 19'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rr_mem_req", 19'(mem_req), 19'd0);
        check("rr_mem_we", 19'(mem_we), 19'd0);
        check("rr_StallM", 19'(StallM), 19'd0);
        @(posedge clk); #1;
        check("rr_state_after", 19'(dbg_state), 19'd0);
        check_w("rr", 0, 0, 5'd0, 19'h0, 19'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 5'd0, 19'h0, 19'h00010, 0, 19'h0, 1);
        #1;
        check("rr_post_mem_we", 19'(mem_we), 19'd0);
        @(posedge clk); #1;
        check("rr_mem_word", mem_word, 19'h12311);
        check("rr_writes", 19'(n_writes), 19'd0);

        // Reset while W holds a live bundle clears it.
        @(negedge clk);
        drive(1, 0, 0, 5'd21, 19'h0, 19'h05555, 0, 19'h0, 0);
        @(posedge clk); #1;
        check("rw_RDW_live", 19'(RDW), 19'd21);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_w("rw", 0, 0, 5'd0, 19'h0, 19'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage of the 19-bit core: consumes the M-stage bundle from the Execute stage's output register and runs the data-memory access through a request/ready handshake. Supports word and byte (Cant_Byte) loads and stores, with byte stores done as read-modify-write. Registers the result into the M/W pipeline register for Writeback, and raises StallM to the hazard unit while an access is outstanding.

## Interface
- No parameters; widths fixed: data 19 bits, data address 15 bits, register index 5 bits.
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- RegWriteM  input  1  register write enable of the M-stage instruction
- MemWriteM  input  1  store
- ResultSrcM  input  1  load (result comes from memory)
- RDM  input  5  destination register
- WriteDataM  input  19  store data (forwarded RD2)
- ALUResultM  input  19  effective address in [14:0] / ALU result
- Cant_ByteM  input  1  1 = byte access (bits [7:0]), 0 = 19-bit word
- mem_rdata  input  19  data-memory read data, valid when mem_ready=1
- mem_ready  input  1  memory completes the current request this cycle
- mem_req  output  1  access request (combinational)
- mem_we  output  1  1 = write, 0 = read (combinational)
- mem_addr  output  15  ALUResultM[14:0] (combinational)
- mem_wdata  output  19  write data (combinational)
- StallM  output  1  freeze F/D/E and the E/M register this cycle (combinational)
- RegWriteW  output  1  registered
- ResultSrcW  output  1  registered
- RDW  output  5  registered
- ALUResultW  output  19  registered
- ReadDataW  output  19  registered

## Operation
- Memory op = MemWriteM | ResultSrcM. If both are set, treat as a store only: no read result, ReadDataW=0.
- FSM states: IDLE and RMW_WR.
- IDLE, no memory op:
  - mem_req=0, StallM=0.
  - W captures RegWriteM/ResultSrcM/RDM/ALUResultM; ReadDataW=0.
- IDLE, load (word or byte):
  - mem_req=1, mem_we=0.
  - If mem_ready: StallM=0; W captures the bundle. ReadDataW = Cant_ByteM ? {11'b0, mem_rdata[7:0]} : mem_rdata.
  - Else: StallM=1; W gets a bubble (RegWriteW=0, ResultSrcW=0, other W fields 0).
- IDLE, word store:
  - mem_req=1, mem_we=1, mem_wdata=WriteDataM.
  - If mem_ready: W captures the bundle; else stall and bubble as for a load.
- IDLE, byte store (phase 1, read):
  - mem_req=1, mem_we=0, StallM=1.
  - On mem_ready: latch merged = {mem_rdata[18:8], WriteDataM[7:0]} and go to RMW_WR.
  - W gets a bubble every cycle in this phase.
- RMW_WR (phase 2, write):
  - mem_req=1, mem_we=1, mem_wdata=merged.
  - StallM = ~mem_ready.
  - On mem_ready: W captures the bundle, go to IDLE.
- While StallM=1 the M inputs are held stable by upstream. This block re-reads them every cycle and keeps no copy except merged.
- mem_addr is driven from ALUResultM[14:0] in every state.

## Timing
- Zero-wait memory (mem_ready high in the request cycle): word access takes 1 cycle with no stall; byte store takes 2 cycles with 1 stall cycle.
- Each wait cycle adds exactly 1 stall cycle.
- W outputs change only on a clock edge: one cycle after the M bundle completes, or a bubble.
- Reset (synchronous, active-high):
  - state=IDLE, merged=0, all W outputs 0.
  - mem_req, mem_we and StallM forced to 0 while reset=1.
  - Reset during RMW_WR abandons the write; no mem_we pulse follows.
- mem_ready is ignored when mem_req=0.
- mem_ready in the same cycle as a state transition is consumed once; no double capture.
- Back-to-back memory ops: the next op's request starts in the cycle after completion. There are no idle cycles between ops.

## Test plan
- Reset then ALU op (RegWriteM=1, RDM=5, ALUResultM=0x1234, no mem op) -> next cycle RegWriteW=1, RDW=5, ALUResultW=0x1234, ReadDataW=0, StallM never high.
- Word load at addr 0x0040, mem_ready low 2 cycles then high, mem_rdata=0x7ABCD -> StallM=1 for 2 cycles with RegWriteW=0 bubbles, then ReadDataW=0x7ABCD, ResultSrcW=1.
- Byte load, zero-wait, mem_rdata=0x7ABCD -> no stall, ReadDataW=0x000CD.
- Byte store WriteDataM=0x000EE to addr 0x0010, memory holds 0x12345, zero-wait -> cycle 1: read request with StallM=1; cycle 2: write request with mem_wdata=0x123EE, StallM=0; memory then reads back 0x123EE.
- Byte store with reset asserted in RMW_WR -> no write request is issued, memory keeps its old word, and all outputs read 0 on the next cycle.
- Load with MemWriteM=1 and ResultSrcM=1 together -> a single write is issued, ReadDataW=0.
